ysyx_22051013_scoreboard: RTL
=============================

# ysyx_22051013_scoreboard

Register scoreboard and issue controller between the decode stage and the execute stage. It tracks, for each architectural register, how many issued instructions still have a write to it outstanding. It stalls decode on RAW/WAW hazards, on a full in-flight window, and on CSR/system instructions that need serialization. It retires entries on writeback and clears everything on a pipeline flush.

## Interface
Parameters:
- CNTW, 2: width of each per-register pending counter; allows 2^CNTW-1 outstanding writes per register.
- MAXINF, 8: maximum number of in-flight (issued, not retired) instructions; power of two, ≤16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a valid decoded instruction.
- id_rs1_ena / id_rs2_ena  in  1  source operand read enables from decode.
- id_rs1_addr / id_rs2_addr  in  5  source register addresses.
- id_rd_ena  in  1  instruction writes rd.
- id_rd_addr  in  5  destination register address.
- id_csr  in  1  instruction touches CSRs or is ECALL/MRET; high when any decode csr_ctl bit is set.
- ex_ready  in  1  execute stage accepts an instruction this cycle.
- wb_valid  in  1  an instruction retires this cycle.
- wb_rd_ena  in  1  the retiring instruction wrote a register.
- wb_rd_addr  in  5  destination of the retiring instruction.
- flush  in  1  kill all in-flight instructions (branch/jump/trap redirect).
- issue  out  1  instruction transfers decode→execute this cycle.
- stall  out  1  decode must hold its current instruction.
- inflight  out  $clog2(MAXINF)+1  number of issued, unretired instructions.
- sb_err  out  1  sticky protocol-error flag.

## Operation
- x0 is never tracked. rd/rs address 0 never causes a hazard and never increments a counter.
- A source hazard exists when a source is enabled, its address is nonzero, and that register's counter is nonzero.
- A WAW/saturation hazard exists when id_rd_ena is set and the rd counter equals 2^CNTW-1.
- A window-full hazard exists when inflight == MAXINF.
- A serialization hazard exists when id_csr is set and inflight != 0.
- stall = id_valid & (any hazard | flush).
- issue = id_valid & ~stall & ex_ready.
- issue with id_rd_ena and rd≠0 increments the rd counter. issue always increments inflight.
- wb_valid always decrements inflight. wb_valid with wb_rd_ena and rd≠0 decrements the wb_rd counter.
- Issue and retire to the same register in the same cycle leave its counter unchanged. The same holds for inflight.
- Retire while inflight == 0, or retire to a register whose counter is 0, sets sb_err. The offending decrement is suppressed and the counter stays 0.
- flush: at the next edge all counters and inflight are cleared, and any same-cycle wb_valid is ignored. issue is 0 during a flush cycle.

## Timing
- stall and issue are combinational from inputs and registered state, with no added latency.
- Counters, inflight and sb_err are registered and update on the rising clk edge.
- A retire at edge N unblocks a dependent instruction in the cycle after edge N. With the bypass option below, the dependent instruction is unblocked in the same cycle as the retire.
- Reset values: all counters 0, inflight 0, sb_err 0.
- While rst is low, issue is forced to 0 and stall = id_valid.
- Reset asserted mid-operation discards all tracking immediately (asynchronous).

## Configuration
- YSYX_22051013_SB_WB_BYPASS_EN defined:
  - A source hazard is ignored when the register's counter is 1 and wb_valid & wb_rd_ena & wb_rd_addr match that register this cycle; the register file write-through supplies the value.
  - The serialization hazard is ignored when inflight == 1 and wb_valid is high.
- Undefined: no bypass. Dependent and CSR instructions wait until the counter or inflight reads 0, which costs one extra cycle.

## Test plan
- Back-to-back RAW: issue `add x5` (rd=5), next `sub` reading rs1=5 with wb idle. Required: stall=1 and counter[5]=1. Then wb_valid with rd=5: without bypass, issue happens the following cycle; with bypass, issue happens the same cycle.
- x0 writes: issue 4 instructions with rd=0, then one reading rs1=0. Required: no stall, inflight=5, all counters 0.
- Window full, MAXINF=8: issue 8 independent instructions with no retire. Required: the 9th is held with stall=1. A single wb_valid gives issue=1 on the next cycle.
- Saturation, CNTW=2: issue 3 writes to x7. Required: the 4th write to x7 stalls, while a write to x8 issues.
- CSR serialization: inflight=2, then csrrw. Required: stall until inflight=0, then issue. Simultaneous issue+retire on rd=3 leaves counter[3] unchanged.
- flush with inflight=5 and counters nonzero. Required: next cycle all counters 0, inflight 0, and issue=0 during the flush cycle. Then a spurious wb_valid sets sb_err=1, and it holds until rst goes low.

Source files
------------

// File: rtl/ysyx_22051013_scoreboard.sv
// Register scoreboard / issue controller between decode and execute.
// Optional macro YSYX_22051013_SB_WB_BYPASS_EN lets a same-cycle writeback release RAW and CSR stalls.
module ysyx_22051013_scoreboard #(
  parameter  int CNTW   = 2,
  parameter  int MAXINF = 8,
  localparam int IFW    = $clog2(MAXINF) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic           id_rs1_ena,
  input  logic [4:0]     id_rs1_addr,
  input  logic           id_rs2_ena,
  input  logic [4:0]     id_rs2_addr,
  input  logic           id_rd_ena,
  input  logic [4:0]     id_rd_addr,
  input  logic           id_csr,
  input  logic           ex_ready,
  input  logic           wb_valid,
  input  logic           wb_rd_ena,
  input  logic [4:0]     wb_rd_addr,
  input  logic           flush,
  output logic           issue,
  output logic           stall,
  output logic [IFW-1:0] inflight,
  output logic           sb_err
);

  // Handshake: an instruction moves decode->execute (issue) in a cycle where id_valid
  // and ex_ready are both high and stall is low; while stall is high decode holds it.
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [IFW-1:0]  INF_MAX = IFW'(MAXINF);
  localparam logic [IFW-1:0]  INF_ONE = IFW'(1);

  logic [CNTW-1:0] cnt_q [32];
  logic [CNTW-1:0] cnt_d [32];
  logic [IFW-1:0]  inflight_q, inflight_d;
  logic            sb_err_q, sb_err_d;

  logic rs1_haz, rs2_haz, waw_haz, full_haz, ser_haz, any_haz;
  logic wb_eff;

  always_comb begin
    rs1_haz  = id_rs1_ena && (id_rs1_addr != 5'd0) && (cnt_q[id_rs1_addr] != '0);
    rs2_haz  = id_rs2_ena && (id_rs2_addr != 5'd0) && (cnt_q[id_rs2_addr] != '0);
    ser_haz  = id_csr && (inflight_q != '0);
`ifdef YSYX_22051013_SB_WB_BYPASS_EN
    // The last outstanding write retiring now reaches the register file by write-through.
    if ((cnt_q[id_rs1_addr] == CNT_ONE) && wb_valid && wb_rd_ena && (wb_rd_addr == id_rs1_addr))
      rs1_haz = 1'b0;
    if ((cnt_q[id_rs2_addr] == CNT_ONE) && wb_valid && wb_rd_ena && (wb_rd_addr == id_rs2_addr))
      rs2_haz = 1'b0;
    if ((inflight_q == INF_ONE) && wb_valid)
      ser_haz = 1'b0;
`endif
    waw_haz  = id_rd_ena && (cnt_q[id_rd_addr] == CNT_MAX);
    full_haz = (inflight_q == INF_MAX);
    any_haz  = rs1_haz | rs2_haz | waw_haz | full_haz | ser_haz;
    stall    = id_valid & (~rst | any_haz | flush);
    issue    = rst & id_valid & ~stall & ex_ready;
  end

  // A flush kills everything in flight, so a writeback in the same cycle is dropped.
  assign wb_eff = wb_valid & ~flush;

  always_comb begin
    logic inc, dec, ret;
    sb_err_d   = sb_err_q;
    inflight_d = inflight_q;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      inc = issue && id_rd_ena && (id_rd_addr == 5'(r)) && (r != 0);
      dec = wb_eff && wb_rd_ena && (wb_rd_addr == 5'(r)) && (r != 0);
      if (dec && (cnt_q[r] == '0)) begin
        sb_err_d = 1'b1;
        dec      = 1'b0;
      end
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
    ret = wb_eff;
    if (ret && (inflight_q == '0)) begin
      sb_err_d = 1'b1;
      ret      = 1'b0;
    end
    inflight_d = inflight_q + IFW'(issue) - IFW'(ret);
    if (flush) begin
      for (int r = 0; r < 32; r++) cnt_d[r] = '0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      inflight_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign inflight = inflight_q;
  assign sb_err   = sb_err_q;

endmodule
